// File: rtl/stopwatch_control.sv
// Stopwatch front end: two-flop button synchronisers, per-button debouncers,
// IDLE/RUN/PAUSE control FSM and the tick prescaler that clocks digit 0.
module stopwatch_control #(
  parameter int TICK_DIV        = 500000,
  parameter int DIV_W           = 20,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_startstop,
  input  logic btn_clear,
  output logic tick,
  output logic clear,
  output logic running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int SS = 0;
  localparam int CL = 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [1:0]      w_btn_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_db;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  state_t           r_state;
  state_t           w_next;
  logic             w_clear;
  logic [DIV_W-1:0] r_presc;
  logic             r_tick;
  logic             r_clear;
  logic             r_running;

  assign w_btn_raw = {btn_clear, btn_startstop};

  // A level is accepted only after it has differed from the debounced level
  // for DEBOUNCE_CYCLES consecutive cycles; only the rising edge is a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchroniser stages as
      // separate flops; blocking here would collapse them into one.
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both signals (no latches).
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_press[CL])      w_clear = 1'b1;
        else if (r_press[SS]) w_next  = S_RUN;
      end
      S_RUN: begin
        if (r_press[SS]) w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (r_press[CL]) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (r_press[SS]) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs and prescaler follow the next state so they line up with the
  // registered state: tick lands in RUN cycle TICK_DIV, never outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_clear   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clear   <= w_clear;
      r_running <= (w_next == S_RUN);
      r_tick    <= 1'b0;
      case (w_next)
        S_RUN: begin
          if (r_presc == DIV_LAST) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        S_PAUSE: r_presc <= r_presc;
        default: r_presc <= '0;
      endcase
    end
  end

  assign tick    = r_tick;
  assign clear   = r_clear;
  assign running = r_running;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with TICK_DIV=5, DEBOUNCE_CYCLES=4:
// a raw press changes state on the 7th clock edge after it is applied.
module tb_stopwatch_control;

  logic clk;
  logic rst;
  logic btn_startstop;
  logic btn_clear;
  logic tick;
  logic clear;
  logic running;

  int total;
  int bad;
  int run_cnt;

  stopwatch_control #(
    .TICK_DIV       (5),
    .DIV_W          (3),
    .DEBOUNCE_CYCLES(4),
    .DB_W           (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_startstop(btn_startstop),
    .btn_clear    (btn_clear),
    .tick         (tick),
    .clear        (clear),
    .running      (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; in RUN the bench counts RUN cycles and expects a tick on every 5th.
  task automatic cyc(input logic exp_run, input logic exp_clr, input string tag);
    @(posedge clk);
    #1;
    if (exp_run) run_cnt++;
    check({tag, "/running"}, {7'd0, running}, {7'd0, exp_run});
    check({tag, "/tick"}, {7'd0, tick}, {7'd0, exp_run && (run_cnt % 5 == 0)});
    check({tag, "/clear"}, {7'd0, clear}, {7'd0, exp_clr});
  endtask

  initial begin
    total = 0;
    bad = 0;
    run_cnt = 0;
    rst = 1'b1;
    btn_startstop = 1'b0;
    btn_clear = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b0, "reset");
    rst = 1'b0;
    check("reset/presc", {5'd0, dut.r_presc}, 8'd0);
    cyc(1'b0, 1'b0, "post_reset");

    // 1. Start from IDLE: state changes on edge 7, ticks at RUN cycles 5,10,15
    btn_startstop = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, "t1_wait");
    cyc(1'b1, 1'b0, "t1_start");
    btn_startstop = 1'b0;
    repeat (14) cyc(1'b1, 1'b0, "t1_run");

    // 2. Glitch of DEBOUNCE_CYCLES-1 cycles is not a press
    btn_startstop = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, "t2_glitch");
    btn_startstop = 1'b0;
    repeat (9) cyc(1'b1, 1'b0, "t2_run");

    // 3. Pause with prescaler=3, wait 20 cycles, resume -> tick 2 cycles later
    btn_startstop = 1'b1;
    repeat (6) cyc(1'b1, 1'b0, "t3_wait");
    cyc(1'b0, 1'b0, "t3_pause");
    btn_startstop = 1'b0;
    check("t3/presc_held", {5'd0, dut.r_presc}, 8'd3);
    repeat (20) cyc(1'b0, 1'b0, "t3_paused");
    check("t3/presc_still", {5'd0, dut.r_presc}, 8'd3);
    btn_startstop = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, "t3_rwait");
    cyc(1'b1, 1'b0, "t3_resume1");
    btn_startstop = 1'b0;
    cyc(1'b1, 1'b0, "t3_resume2");
    check("t3/tick_after_resume", {7'd0, tick}, 8'd1);

    // 4a. Clear in RUN is ignored
    btn_clear = 1'b1;
    repeat (8) cyc(1'b1, 1'b0, "t4_clr_run");
    btn_clear = 1'b0;
    repeat (8) cyc(1'b1, 1'b0, "t4_run");
    // 4b. Pause, then clear -> single clear pulse, IDLE, fresh start
    btn_startstop = 1'b1;
    repeat (6) cyc(1'b1, 1'b0, "t4_pwait");
    cyc(1'b0, 1'b0, "t4_pause");
    btn_startstop = 1'b0;
    repeat (8) cyc(1'b0, 1'b0, "t4_paused");
    btn_clear = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, "t4_cwait");
    cyc(1'b0, 1'b1, "t4_clear");
    run_cnt = 0;
    btn_clear = 1'b0;
    cyc(1'b0, 1'b0, "t4_clear_end");
    check("t4/presc_zero", {5'd0, dut.r_presc}, 8'd0);
    repeat (6) cyc(1'b0, 1'b0, "t4_idle");
    btn_startstop = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, "t4_swait");
    cyc(1'b1, 1'b0, "t4_restart");
    btn_startstop = 1'b0;
    repeat (7) cyc(1'b1, 1'b0, "t4_rerun");

    // 5a. Both presses together in PAUSE -> IDLE with clear pulse
    btn_startstop = 1'b1;
    repeat (6) cyc(1'b1, 1'b0, "t5_pwait");
    cyc(1'b0, 1'b0, "t5_pause");
    btn_startstop = 1'b0;
    repeat (8) cyc(1'b0, 1'b0, "t5_paused");
    btn_startstop = 1'b1;
    btn_clear = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, "t5_bwait");
    cyc(1'b0, 1'b1, "t5_both_pause");
    run_cnt = 0;
    btn_startstop = 1'b0;
    btn_clear = 1'b0;
    repeat (9) cyc(1'b0, 1'b0, "t5_idle");
    // 5b. Both presses together in IDLE -> clear pulse, stays IDLE
    btn_startstop = 1'b1;
    btn_clear = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, "t5_iwait");
    cyc(1'b0, 1'b1, "t5_both_idle");
    btn_startstop = 1'b0;
    btn_clear = 1'b0;
    repeat (9) cyc(1'b0, 1'b0, "t5_stay_idle");

    // 6. Reset mid-RUN with prescaler=2 drops outputs immediately
    btn_startstop = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, "t6_wait");
    cyc(1'b1, 1'b0, "t6_run1");
    btn_startstop = 1'b0;
    cyc(1'b1, 1'b0, "t6_run2");
    check("t6/presc_before", {5'd0, dut.r_presc}, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6/running_async", {7'd0, running}, 8'd0);
    check("t6/tick_async", {7'd0, tick}, 8'd0);
    check("t6/clear_async", {7'd0, clear}, 8'd0);
    check("t6/presc_async", {5'd0, dut.r_presc}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cnt = 0;
    check("t6/presc_after", {5'd0, dut.r_presc}, 8'd0);
    repeat (8) cyc(1'b0, 1'b0, "t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
